// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter: arbiter state encoding
// and requester-select constants.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLockA = 2'd1,
        StLockB = 2'd2
    } arbState_t;

    typedef enum logic {
        SelA = 1'b0,
        SelB = 1'b1
    } reqSel_t;

endpackage

// File: rtl/ram_arb_be_expand.sv
// Expands per-byte write enables into a per-bit write mask.
module ram_arb_be_expand #(
    parameter int CBeLen = 2
) (
    input  logic [CBeLen-1:0]   AByteEn,
    output logic [CBeLen*8-1:0] ABitMask
);

    // Replicate each byte enable across its eight data bits.
    always_comb begin
        ABitMask = '0;
        for (int unsigned i = 0; i < CBeLen; i++) begin
            ABitMask[i*8 +: 8] = {8{AByteEn[i]}};
        end
    end

endmodule

// File: rtl/ram_arb2.sv
// Two-requester single-port RAM arbiter with round-robin fairness, atomic
// lock sequences, clock enable and one-cycle registered read-valid tracking.
module ram_arb2
    import ram_arb_pkg::*;
#(
    parameter int CAddrLen = 8,
    parameter int CDataLen = 16
) (
    input  logic                  AClkH,
    input  logic                  AReset,
    input  logic                  AClkHEn,
    input  logic                  AReqA,
    input  logic                  AReqB,
    input  logic                  ALockA,
    input  logic                  ALockB,
    input  logic [CAddrLen-1:0]   AAddrA,
    input  logic [CAddrLen-1:0]   AAddrB,
    input  logic [CDataLen-1:0]   AMosiA,
    input  logic [CDataLen-1:0]   AMosiB,
    input  logic [CDataLen/8-1:0] AWrEnA,
    input  logic [CDataLen/8-1:0] AWrEnB,
    output logic                  AAckA,
    output logic                  AAckB,
    output logic [CDataLen-1:0]   AMisoA,
    output logic [CDataLen-1:0]   AMisoB,
    output logic                  AVldA,
    output logic                  AVldB,
    output logic [CAddrLen-1:0]   ARamAddr,
    output logic [CDataLen-1:0]   ARamMosi,
    output logic [CDataLen-1:0]   ARamWrEn,
    output logic [CDataLen-1:0]   ARamRdEn,
    input  logic [CDataLen-1:0]   ARamMiso
);

    localparam int CBeLen = CDataLen / 8;

    arbState_t             state;
    arbState_t             stateNext;
    reqSel_t               fLast;
    reqSel_t               fLastNext;
    logic                  fVldA;
    logic                  fVldB;
    logic                  grantA;
    logic                  grantB;
    logic [CBeLen-1:0]     selWrEn;
    logic [CDataLen-1:0]   bitMask;

    // Arbitration and next-state: grants are only issued on enabled cycles.
    always_comb begin
        grantA    = 1'b0;
        grantB    = 1'b0;
        stateNext = state;
        if (AClkHEn) begin
            case (state)
                StIdle: begin
                    if (AReqA && AReqB) begin
                        if (fLast == SelA) grantB = 1'b1;
                        else               grantA = 1'b1;
                    end else if (AReqA) begin
                        grantA = 1'b1;
                    end else if (AReqB) begin
                        grantB = 1'b1;
                    end
                end
                StLockA: begin
                    if (AReqA) grantA = 1'b1;
                    else       stateNext = StIdle;
                end
                StLockB: begin
                    if (AReqB) grantB = 1'b1;
                    else       stateNext = StIdle;
                end
                default: stateNext = StIdle;
            endcase
            if (grantA) stateNext = ALockA ? StLockA : StIdle;
            if (grantB) stateNext = ALockB ? StLockB : StIdle;
        end
        fLastNext = fLast;
        if (grantA) fLastNext = SelA;
        if (grantB) fLastNext = SelB;
    end

    // Route the granted requester onto the RAM port; zeros when idle.
    always_comb begin
        ARamAddr = '0;
        ARamMosi = '0;
        selWrEn  = '0;
        if (grantA) begin
            ARamAddr = AAddrA;
            ARamMosi = AMosiA;
            selWrEn  = AWrEnA;
        end else if (grantB) begin
            ARamAddr = AAddrB;
            ARamMosi = AMosiB;
            selWrEn  = AWrEnB;
        end
        ARamRdEn = ((grantA || grantB) && (selWrEn == '0)) ? '1 : '0;
        ARamWrEn = bitMask;
    end

    ram_arb_be_expand #(
        .CBeLen(CBeLen)
    ) uBeExpand (
        .AByteEn (selWrEn),
        .ABitMask(bitMask)
    );

    // State, round-robin pointer and read-valid registers; reset overrides enable.
    always_ff @(posedge AClkH) begin
        if (AReset) begin
            state <= StIdle;
            fLast <= SelB;
            fVldA <= 1'b0;
            fVldB <= 1'b0;
        end else if (AClkHEn) begin
            state <= stateNext;
            fLast <= fLastNext;
            fVldA <= grantA && (AWrEnA == '0);
            fVldB <= grantB && (AWrEnB == '0);
        end
    end

    // Requester-side acks and read data.
    always_comb begin
        AAckA  = grantA;
        AAckB  = grantB;
        AVldA  = fVldA;
        AVldB  = fVldB;
        AMisoA = fVldA ? ARamMiso : '0;
        AMisoB = fVldB ? ARamMiso : '0;
    end

endmodule

// File: tb/tb_ram_arb2.sv
// Directed, table-driven bench for ram_arb2 with a behavioural RAM model.
module tb_ram_arb2;

    logic        clk = 1'b0;
    logic        rst, en;
    logic        reqA, reqB, lockA, lockB;
    logic [7:0]  addrA, addrB;
    logic [15:0] mosiA, mosiB;
    logic [1:0]  weA, weB;
    logic        ackA, ackB, vldA, vldB;
    logic [15:0] misoA, misoB;
    logic [7:0]  ramAddr;
    logic [15:0] ramMosi, ramWrEn, ramRdEn, ramMiso;

    logic [15:0] mem [0:255];
    logic        ramInit;

    int nAsserts = 0;
    int nFail    = 0;

    typedef struct {
        logic        rst, en;
        logic        reqA, lockA; logic [7:0] addrA; logic [15:0] mosiA; logic [1:0] weA;
        logic        reqB, lockB; logic [7:0] addrB; logic [15:0] mosiB; logic [1:0] weB;
        logic        ackA, ackB, vldA, vldB; logic [15:0] misoA, misoB;
        logic [7:0]  rAddr; logic [15:0] rMosi, rWrEn, rRdEn;
    } vec_t;

    vec_t tab [0:20];

    always #5 clk = ~clk;

    ram_arb2 #(
        .CAddrLen(8),
        .CDataLen(16)
    ) dut (
        .AClkH   (clk),
        .AReset  (rst),
        .AClkHEn (en),
        .AReqA   (reqA),
        .AReqB   (reqB),
        .ALockA  (lockA),
        .ALockB  (lockB),
        .AAddrA  (addrA),
        .AAddrB  (addrB),
        .AMosiA  (mosiA),
        .AMosiB  (mosiB),
        .AWrEnA  (weA),
        .AWrEnB  (weB),
        .AAckA   (ackA),
        .AAckB   (ackB),
        .AMisoA  (misoA),
        .AMisoB  (misoB),
        .AVldA   (vldA),
        .AVldB   (vldB),
        .ARamAddr(ramAddr),
        .ARamMosi(ramMosi),
        .ARamWrEn(ramWrEn),
        .ARamRdEn(ramRdEn),
        .ARamMiso(ramMiso)
    );

    // RAM model: preset pattern A000+addr, bit-masked write, one-cycle read.
    always @(posedge clk) begin
        if (ramInit) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'hA000 | 16'(i);
            ramMiso <= '0;
        end else begin
            if (ramRdEn != 16'h0) ramMiso <= mem[ramAddr];
            for (int b = 0; b < 16; b++)
                if (ramWrEn[b]) mem[ramAddr][b] <= ramMosi[b];
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        nAsserts++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyVec(input vec_t v, input string tag);
        @(negedge clk);
        rst = v.rst;   en = v.en;
        reqA = v.reqA; lockA = v.lockA; addrA = v.addrA; mosiA = v.mosiA; weA = v.weA;
        reqB = v.reqB; lockB = v.lockB; addrB = v.addrB; mosiB = v.mosiB; weB = v.weB;
        #2;
        chk({tag, ".ackA"},  16'(ackA),  16'(v.ackA));
        chk({tag, ".ackB"},  16'(ackB),  16'(v.ackB));
        chk({tag, ".vldA"},  16'(vldA),  16'(v.vldA));
        chk({tag, ".vldB"},  16'(vldB),  16'(v.vldB));
        chk({tag, ".misoA"}, misoA,      v.misoA);
        chk({tag, ".misoB"}, misoB,      v.misoB);
        chk({tag, ".rAddr"}, 16'(ramAddr), 16'(v.rAddr));
        chk({tag, ".rMosi"}, ramMosi,    v.rMosi);
        chk({tag, ".rWrEn"}, ramWrEn,    v.rWrEn);
        chk({tag, ".rRdEn"}, ramRdEn,    v.rRdEn);
    endtask

    initial begin
        vec_t h;
        // rst,en | reqA,lockA,addrA,mosiA,weA | reqB,lockB,addrB,mosiB,weB |
        // ackA,ackB,vldA,vldB,misoA,misoB | rAddr,rMosi,rWrEn,rRdEn
        tab[0]  = '{1,1, 0,0,8'h00,16'h0000,2'b00, 0,0,8'h00,16'h0,2'b00, 0,0,0,0,16'h0000,16'h0000, 8'h00,16'h0000,16'h0000,16'h0000};
        tab[1]  = '{0,1, 1,0,8'h10,16'h0000,2'b00, 0,0,8'h00,16'h0,2'b00, 1,0,0,0,16'h0000,16'h0000, 8'h10,16'h0000,16'h0000,16'hFFFF};
        tab[2]  = '{0,1, 0,0,8'h00,16'h0000,2'b00, 0,0,8'h00,16'h0,2'b00, 0,0,1,0,16'hA010,16'h0000, 8'h00,16'h0000,16'h0000,16'h0000};
        tab[3]  = '{1,1, 0,0,8'h00,16'h0000,2'b00, 0,0,8'h00,16'h0,2'b00, 0,0,0,0,16'h0000,16'h0000, 8'h00,16'h0000,16'h0000,16'h0000};
        tab[4]  = '{0,1, 1,0,8'h01,16'h0000,2'b00, 1,0,8'h02,16'h0,2'b00, 1,0,0,0,16'h0000,16'h0000, 8'h01,16'h0000,16'h0000,16'hFFFF};
        tab[5]  = '{0,1, 1,0,8'h01,16'h0000,2'b00, 1,0,8'h02,16'h0,2'b00, 0,1,1,0,16'hA001,16'h0000, 8'h02,16'h0000,16'h0000,16'hFFFF};
        tab[6]  = '{0,1, 1,0,8'h01,16'h0000,2'b00, 1,0,8'h02,16'h0,2'b00, 1,0,0,1,16'h0000,16'hA002, 8'h01,16'h0000,16'h0000,16'hFFFF};
        tab[7]  = '{0,1, 1,0,8'h01,16'h0000,2'b00, 1,0,8'h02,16'h0,2'b00, 0,1,1,0,16'hA001,16'h0000, 8'h02,16'h0000,16'h0000,16'hFFFF};
        tab[8]  = '{0,0, 1,0,8'h01,16'h0000,2'b00, 1,0,8'h02,16'h0,2'b00, 0,0,0,1,16'h0000,16'hA002, 8'h00,16'h0000,16'h0000,16'h0000};
        tab[9]  = '{0,0, 1,0,8'h01,16'h0000,2'b00, 1,0,8'h02,16'h0,2'b00, 0,0,0,1,16'h0000,16'hA002, 8'h00,16'h0000,16'h0000,16'h0000};
        tab[10] = '{0,0, 1,0,8'h01,16'h0000,2'b00, 1,0,8'h02,16'h0,2'b00, 0,0,0,1,16'h0000,16'hA002, 8'h00,16'h0000,16'h0000,16'h0000};
        tab[11] = '{0,1, 1,0,8'h01,16'h0000,2'b00, 1,0,8'h02,16'h0,2'b00, 1,0,0,1,16'h0000,16'hA002, 8'h01,16'h0000,16'h0000,16'hFFFF};
        tab[12] = '{0,1, 1,0,8'h01,16'h0000,2'b00, 1,0,8'h02,16'h0,2'b00, 0,1,1,0,16'hA001,16'h0000, 8'h02,16'h0000,16'h0000,16'hFFFF};
        tab[13] = '{0,1, 1,1,8'h05,16'h1234,2'b01, 1,0,8'h02,16'h0,2'b00, 1,0,0,1,16'h0000,16'hA002, 8'h05,16'h1234,16'h00FF,16'h0000};
        tab[14] = '{0,1, 1,1,8'h05,16'h0000,2'b00, 1,0,8'h02,16'h0,2'b00, 1,0,0,0,16'h0000,16'h0000, 8'h05,16'h0000,16'h0000,16'hFFFF};
        tab[15] = '{0,1, 1,0,8'h06,16'h0000,2'b00, 1,0,8'h02,16'h0,2'b00, 1,0,1,0,16'hA034,16'h0000, 8'h06,16'h0000,16'h0000,16'hFFFF};
        tab[16] = '{0,1, 1,0,8'h07,16'h0000,2'b00, 1,0,8'h02,16'h0,2'b00, 0,1,1,0,16'hA006,16'h0000, 8'h02,16'h0000,16'h0000,16'hFFFF};
        tab[17] = '{0,1, 1,1,8'h07,16'h0000,2'b00, 1,0,8'h02,16'h0,2'b00, 1,0,0,1,16'h0000,16'hA002, 8'h07,16'h0000,16'h0000,16'hFFFF};
        tab[18] = '{0,1, 0,0,8'h00,16'h0000,2'b00, 1,0,8'h02,16'h0,2'b00, 0,0,1,0,16'hA007,16'h0000, 8'h00,16'h0000,16'h0000,16'h0000};
        tab[19] = '{0,1, 0,0,8'h00,16'h0000,2'b00, 1,0,8'h02,16'h0,2'b00, 0,1,0,0,16'h0000,16'h0000, 8'h02,16'h0000,16'h0000,16'hFFFF};
        tab[20] = '{0,1, 0,0,8'h00,16'h0000,2'b00, 0,0,8'h00,16'h0,2'b00, 0,0,0,1,16'h0000,16'hA002, 8'h00,16'h0000,16'h0000,16'h0000};

        rst = 1'b1; en = 1'b1; ramInit = 1'b1;
        reqA = 1'b0; lockA = 1'b0; addrA = '0; mosiA = '0; weA = '0;
        reqB = 1'b0; lockB = 1'b0; addrB = '0; mosiB = '0; weB = '0;
        repeat (2) @(negedge clk);
        ramInit = 1'b0;

        for (int i = 0; i < 21; i++) applyVec(tab[i], $sformatf("row%0d", i));

        // Lock B, then reset while locked with B's read data pending.
        h = '{0,1, 0,0,8'h00,16'h0000,2'b00, 1,1,8'h03,16'h0,2'b00, 0,1,0,0,16'h0000,16'h0000, 8'h03,16'h0000,16'h0000,16'hFFFF};
        applyVec(h, "lockB");
        h = '{1,1, 1,0,8'h04,16'h0000,2'b00, 1,1,8'h03,16'h0,2'b00, 0,1,0,1,16'h0000,16'hA003, 8'h03,16'h0000,16'h0000,16'hFFFF};
        applyVec(h, "rstInLockB");
        h = '{0,1, 1,0,8'h04,16'h0000,2'b00, 1,1,8'h03,16'h0,2'b00, 1,0,0,0,16'h0000,16'h0000, 8'h04,16'h0000,16'h0000,16'hFFFF};
        applyVec(h, "afterRst");

        // High-byte write from B onto the previously low-byte-written word.
        h = '{0,1, 0,0,8'h00,16'h0000,2'b00, 1,0,8'h05,16'hBEEF,2'b10, 0,1,1,0,16'hA004,16'h0000, 8'h05,16'hBEEF,16'hFF00,16'h0000};
        applyVec(h, "wrHiB");
        h = '{0,1, 1,0,8'h05,16'h0000,2'b00, 0,0,8'h00,16'h0,2'b00, 1,0,0,0,16'h0000,16'h0000, 8'h05,16'h0000,16'h0000,16'hFFFF};
        applyVec(h, "rdBackA");
        h = '{0,1, 0,0,8'h00,16'h0000,2'b00, 0,0,8'h00,16'h0,2'b00, 0,0,1,0,16'hBE34,16'h0000, 8'h00,16'h0000,16'h0000,16'h0000};
        applyVec(h, "rdBackData");

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule

// File: doc/ram_arb2.md
RAM_ARB2 -- requirements
Module: ram_arb2

Interface
REQ-001 SHALL have parameter CAddrLen, default 8, RAM word-address width.
REQ-002 SHALL have parameter CDataLen, default 16, data width; multiple of 8; CBeLen = CDataLen/8.
REQ-003 SHALL have port AClkH, in, 1, single clock, rising edge.
REQ-004 SHALL have port AReset, in, 1, reset, synchronous and active-high.
REQ-005 SHALL have port AClkHEn, in, 1, clock enable; low = all registers hold.
REQ-006 SHALL have ports AReqA/AReqB, in, 1, access request, held until acked.
REQ-007 SHALL have ports ALockA/ALockB, in, 1, keep grant after this access (atomic sequence).
REQ-008 SHALL have ports AAddrA/AAddrB, in, CAddrLen, word address.
REQ-009 SHALL have ports AMosiA/AMosiB, in, CDataLen, write data.
REQ-010 SHALL have ports AWrEnA/AWrEnB, in, CBeLen, byte write enables; all-zero = read.
REQ-011 SHALL have ports AAckA/AAckB, out, 1, access issued to RAM this cycle.
REQ-012 SHALL have ports AMisoA/AMisoB, out, CDataLen, read data; zero when not valid.
REQ-013 SHALL have ports AVldA/AVldB, out, 1, read data valid.
REQ-014 SHALL have port ARamAddr, out, CAddrLen, RAM address.
REQ-015 SHALL have port ARamMosi, out, CDataLen, RAM write data.
REQ-016 SHALL have port ARamWrEn, out, CDataLen, per-bit write mask.
REQ-017 SHALL have port ARamRdEn, out, CDataLen, per-bit read mask.
REQ-018 SHALL have port ARamMiso, in, CDataLen, RAM read data, valid one cycle after ARamRdEn.

Function
REQ-019 SHALL arbitrate combinationally each enabled cycle; at most one of AAckA/AAckB high.
REQ-020 SHALL grant the sole requester when only one requests and state is IDLE.
REQ-021 SHALL, both requesting in IDLE, grant the requester not granted last (FLast), round-robin.
REQ-022 SHALL update FLast to the acked requester on every ack.
REQ-023 SHALL have states IDLE, LOCK_A, LOCK_B; ack of X with ALockX=1 -> LOCK_X.
REQ-024 SHALL in LOCK_X grant only X; other requester waits regardless of FLast.
REQ-025 SHALL leave LOCK_X to IDLE on ack of X with ALockX=0, or any enabled cycle with AReqX=0.
REQ-026 SHALL drive, for granted X: ARamAddr=AAddrX, ARamMosi=AMosiX, ARamWrEn=bit-expanded AWrEnX.
REQ-027 SHALL drive ARamRdEn all-ones for a granted read, all-zeros for a write.
REQ-028 SHALL drive ARamAddr, ARamMosi, ARamWrEn, ARamRdEn to zero when no grant or AClkHEn=0.
REQ-029 SHALL force AAckA/AAckB to 0 when AClkHEn=0.
REQ-030 SHALL register FVldX=1 on the enabled edge after a read ack to X, else 0; AVldX=FVldX.
REQ-031 SHALL drive AMisoX = FVldX ? ARamMiso : 0 (read latency exactly 1 cycle after ack).
REQ-032 SHALL allow back-to-back acks each enabled cycle; new read ack and prior read data coexist.

Reset
REQ-033 SHALL on AReset=1 at a clock edge (regardless of AClkHEn) set state IDLE, FLast=B, FVldA=FVldB=0.
REQ-034 SHALL, reset mid-lock, drop the lock; outputs after reset: AAck 0 unless requested, AVld 0, AMiso 0.

Structure
REQ-035 SHALL place state encoding (IDLE/LOCK_A/LOCK_B) and requester-select constants in shared package ram_arb_pkg.
REQ-036 SHALL use one sub-module ram_arb_be_expand (CBeLen byte enables -> CDataLen bit mask).

Verification
REQ-037 After reset, AReqA=1 read addr 0x10 -> AAckA same cycle, ARamRdEn=0xFFFF, next cycle AVldA=1, AMisoA=RAM[0x10].
REQ-038 Both request continuously, no lock -> acks alternate A,B,A,B starting with A after reset.
REQ-039 A writes 0x1234 to 0x05 with AWrEnA=2'b01, ALockA=1; B requesting -> B blocked until A's unlocked access; RAM[0x05] low byte=0x34.
REQ-040 LOCK_A, then AReqA=0 for one cycle -> IDLE, B acked next cycle.
REQ-041 AClkHEn=0 for 3 cycles with both requesting -> no acks, RAM enables 0, FLast/state unchanged; resume continues order.
REQ-042 AReset=1 while in LOCK_B with FVldB=1 -> next cycle IDLE, AVldB=0, A wins simultaneous request.
